// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan controller: state codes,
// active-low glyphs, off patterns and the hex-to-segment decoder.
package seg7_pkg;

  localparam logic       SHOW     = 1'b0;
  localparam logic       GAP      = 1'b1;

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [3:0] AN_OFF   = 4'b1111;
  localparam logic [3:0] RING_RST = 4'b1110;

  // Active-low, bit order {g,f,e,d,c,b,a}; entry [15] is F, entry [0] is 0.
  localparam logic [15:0][6:0] GLYPH = '{
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    return GLYPH[h];
  endfunction

endpackage

// File: rtl/seg7_digit_ring.sv
// Rotating one-cold digit-select ring; rotates left one place per enable.
module seg7_digit_ring
  import seg7_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       si,
  output logic [3:0] q
);

  always_ff @(posedge clk) begin
    if (rst)     q <= RING_RST;
    else if (en) q <= {q[2:0], si};
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// 4-digit seven-segment scan controller with per-frame input shadowing and
// an anode-off gap between digits. Option: SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50000,
  parameter int unsigned GAP_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int unsigned PMAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int unsigned PW   = (PMAX > 1) ? $clog2(PMAX) : 1;
  localparam logic [PW-1:0] SHOW_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] GAP_LAST  = (GAP_CYC > 0) ? PW'(GAP_CYC - 1) : '0;

  logic          state;
  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [3:0]    ring;
  logic [15:0]   sh_digits;
  logic [3:0]    sh_dp, sh_blank;
  logic          show_done, gap_done, adv, wrap;
  logic [3:0]    lz_mask, blank;
  logic [3:0]    nib;
  logic          off;

  always_comb begin
    show_done = (state == SHOW) && (presc == SHOW_LAST);
    gap_done  = (state == GAP)  && (presc == GAP_LAST);
    adv       = (show_done && (GAP_CYC == 0)) || gap_done;
    wrap      = adv && (idx == 2'd3);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SHOW;
      presc      <= '0;
      idx        <= '0;
      sh_digits  <= '0;
      sh_dp      <= '0;
      sh_blank   <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= wrap;
      idx        <= idx + {1'b0, adv};
      if (show_done && (GAP_CYC != 0)) begin
        state <= GAP;
        presc <= '0;
      end else if (adv) begin
        state <= SHOW;
        presc <= '0;
      end else begin
        presc <= presc + 1'b1;
      end
      // Inputs only enter at the frame boundary so a frame never tears.
      if (wrap) begin
        sh_digits <= digits_in;
        sh_dp     <= dp_in;
        sh_blank  <= blank_in;
      end
    end
  end

  seg7_digit_ring u_ring (
    .clk (clk),
    .rst (rst),
    .en  (adv),
    .si  (ring[3]),
    .q   (ring)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  always_comb begin
    lz_mask    = '0;
    lz_mask[3] = (sh_digits[15:12] == 4'h0);
    lz_mask[2] = lz_mask[3] && (sh_digits[11:8] == 4'h0);
    lz_mask[1] = lz_mask[2] && (sh_digits[7:4] == 4'h0);
  end
`else
  assign lz_mask = '0;
`endif

  always_comb begin
    blank = sh_blank | lz_mask;
    nib   = sh_digits[{idx, 2'b00} +: 4];
    off   = (state == GAP) || blank[idx];
    an    = (state == GAP) ? AN_OFF : ring;
    seg   = off ? SEG_OFF : hex2seg(nib);
    dp    = off ? 1'b1 : ~sh_dp[idx];
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench: scan order, gap, shadowing, dp/blank, reset, fast scan.
module tb_seg7_scan_ctrl;

  localparam logic [6:0] G0 = 7'h40, G1 = 7'h79, G2 = 7'h24, G3 = 7'h30,
                         G4 = 7'h19, G5 = 7'h12, GA = 7'h08, GB = 7'h03,
                         GC = 7'h46, GD = 7'h21, OFF = 7'h7F;

  logic        clk = 1'b0;
  logic        rst, rst_f;
  logic [15:0] digits_in;
  logic [3:0]  dp_in, blank_in;
  logic [3:0]  an, an_f;
  logic [6:0]  seg, seg_f;
  logic        dp, dp_f, frame_tick, ft_f;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.CLK_DIV(4), .GAP_CYC(1)) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in),
    .blank_in(blank_in), .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
  );

  seg7_scan_ctrl #(.CLK_DIV(1), .GAP_CYC(0)) dut_fast (
    .clk(clk), .rst(rst_f), .digits_in(digits_in), .dp_in(dp_in),
    .blank_in(blank_in), .an(an_f), .seg(seg_f), .dp(dp_f), .frame_tick(ft_f)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [3:0] ring_of(input int d);
    logic [3:0] r;
    r    = 4'b1111;
    r[d] = 1'b0;
    return r;
  endfunction

  logic [6:0] f1 [4];
  logic [6:0] f2 [4];
  logic [6:0] lz_hi;

  initial begin
    f1 = '{G4, G3, G2, G1};
    f2 = '{GD, GC, GB, GA};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    lz_hi = OFF;
`else
    lz_hi = G0;
`endif
    rst = 1'b1; rst_f = 1'b1;
    digits_in = 16'h1234; dp_in = 4'b0000; blank_in = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_an",  an,  4'hE);
    chk("rst_seg", seg, G0);
    chk("rst_dp",  dp,  1'b1);
    chk("rst_ft",  frame_tick, 1'b0);
    rst = 1'b0;

    for (int c = 0; c <= 71; c++) begin
      int d, pos, fr;
      d = (c / 5) % 4; pos = c % 5; fr = c / 20;
      if (c < 20) begin
        chk("f0_an",  an,  (pos == 4) ? 4'hF : ring_of(d));
        chk("f0_seg", seg, (pos == 4) ? OFF : G0);
        chk("f0_ft",  frame_tick, 1'b0);
      end
      if (c == 20 || c == 40 || c == 60) chk("ft_hi", frame_tick, 1'b1);
      if (c == 21 || c == 39) chk("ft_lo", frame_tick, 1'b0);
      if (fr == 1 && pos == 0) chk("f1_seg", seg, f1[d]);
      if (fr == 1 && pos == 4) chk("f1_gap_an", an, 4'hF);
      if (fr == 2 && pos == 0) chk("f2_seg", seg, f2[d]);
      if (c == 27) digits_in = 16'hABCD;
      if (c == 45) begin dp_in = 4'b0100; blank_in = 4'b0001; end
      if (c == 60) begin
        chk("blk_an", an, 4'hE); chk("blk_seg", seg, OFF); chk("blk_dp", dp, 1'b1);
      end
      if (c == 65) begin
        chk("d1_an", an, 4'hD); chk("d1_seg", seg, GC); chk("d1_dp", dp, 1'b1);
      end
      if (c == 70 || c == 71) begin
        chk("d2_an", an, 4'hB); chk("d2_seg", seg, GB); chk("d2_dp", dp, 1'b0);
      end
      if (c < 71) tick;
    end

    rst = 1'b1;
    tick;
    chk("mid_rst_an",  an,  4'hE);
    chk("mid_rst_seg", seg, G0);
    chk("mid_rst_dp",  dp,  1'b1);
    chk("mid_rst_ft",  frame_tick, 1'b0);
    rst = 1'b0;
    digits_in = 16'h0050; dp_in = 4'b0000; blank_in = 4'b0000;

    for (int c = 0; c < 40; c++) begin
      if (c < 4)   chk("rs_show_an", an, 4'hE);
      if (c == 4)  chk("rs_gap_an",  an, 4'hF);
      if (c == 20) begin chk("lz_ft", frame_tick, 1'b1); chk("lz_d0", seg, G0); end
      if (c == 25) chk("lz_d1", seg, G5);
      if (c == 30) chk("lz_d2", seg, lz_hi);
      if (c == 35) chk("lz_d3", seg, lz_hi);
      tick;
    end

    rst_f = 1'b0;
    chk("fast_seg0", seg_f, G0);
    for (int c = 0; c < 24; c++) begin
      chk("fast_an", an_f, ring_of(c % 4));
      chk("fast_ft", ft_f, (c != 0) && (c % 4 == 0));
      tick;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
